// File: rtl/or_and_sweep.sv
// or_and_sweep: two-stage pipelined AND-of-ORs evaluator with a built-in
// exhaustive sweep that counts how many input combinations give E=1.

// One OR group: reduces GROUP_W operand bits to a single term.
module or_and_sweep_grp #(
    parameter int GROUP_W = 2
) (
    input  logic [GROUP_W-1:0] bits_i,
    output logic               or_o
);
    assign or_o = |bits_i;
endmodule

module or_and_sweep #(
    parameter int N_GROUPS = 2,
    parameter int GROUP_W  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [N_GROUPS*GROUP_W-1:0] in_bits,
    output logic                        out_valid,
    output logic [N_GROUPS*GROUP_W-1:0] out_bits,
    output logic                        out_e,
    output logic                        busy,
    output logic                        done,
    output logic [N_GROUPS*GROUP_W:0]   hit_count
);
    localparam int TOTAL  = N_GROUPS * GROUP_W;
    localparam int STAGES = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [TOTAL-1:0] CNT_MAX = {TOTAL{1'b1}};

    // Sweep control
    logic [1:0]       state_q, state_d;
    logic [TOTAL-1:0] cnt_q, cnt_d;
    logic             drain_q, drain_d;
    logic [TOTAL:0]   hit_q, hit_d;
    logic             busy_q, done_q;
    logic             sweep_start;

    // Operand source for stage 1
    logic [TOTAL-1:0]    src_bits;
    logic                src_vld;
    logic                src_sw;
    logic [N_GROUPS-1:0] grp_or;

    // Pipeline: vld_pipe_q[s] is the valid bit of stage s, sw_pipe_q[s]
    // marks entries that were issued by the sweep (the only ones counted).
    logic [STAGES:1]     vld_pipe_q;
    logic [STAGES:1]     sw_pipe_q;
    logic [TOTAL-1:0]    s1_bits_q;
    logic [N_GROUPS-1:0] s1_or_q;
    logic [TOTAL-1:0]    out_bits_q;
    logic                out_e_q;

    assign sweep_start = (state_q == S_IDLE) && start && mode;

    // Select the stage-1 operand: sweep counter while sweeping, otherwise
    // the external port. External operands are dropped while a sweep is
    // issuing or draining so the sweep window stays contiguous.
    always_comb begin
        src_bits = in_bits;
        src_vld  = in_valid && ((state_q == S_IDLE) || (state_q == S_DONE));
        src_sw   = 1'b0;
        if (state_q == S_SWEEP) begin
            src_bits = cnt_q;
            src_vld  = 1'b1;
            src_sw   = 1'b1;
        end else if (state_q == S_DRAIN) begin
            src_vld  = 1'b0;
        end
    end

    // Per-group OR reduction of the selected operand.
    genvar g;
    generate
        for (g = 0; g < N_GROUPS; g++) begin : g_grp
            or_and_sweep_grp #(
                .GROUP_W (GROUP_W)
            ) u_grp (
                .bits_i (src_bits[g*GROUP_W +: GROUP_W]),
                .or_o   (grp_or[g])
            );
        end
    endgenerate

    // Stage 1: capture operand, valid/sweep tags and the group-OR vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q[1] <= 1'b0;
            sw_pipe_q[1]  <= 1'b0;
            s1_bits_q     <= '0;
            s1_or_q       <= '0;
        end else begin
            vld_pipe_q[1] <= src_vld;
            sw_pipe_q[1]  <= src_sw;
            s1_bits_q     <= src_bits;
            s1_or_q       <= grp_or;
        end
    end

    // Stage 2: AND the group terms; data holds while no valid entry arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q[2] <= 1'b0;
            sw_pipe_q[2]  <= 1'b0;
            out_bits_q    <= '0;
            out_e_q       <= 1'b0;
        end else begin
            vld_pipe_q[2] <= vld_pipe_q[1];
            sw_pipe_q[2]  <= vld_pipe_q[1] && sw_pipe_q[1];
            if (vld_pipe_q[1]) begin
                out_bits_q <= s1_bits_q;
                out_e_q    <= &s1_or_q;
            end
        end
    end

    // Sweep FSM next state: issue 0..2^TOTAL-1 once, then wait two cycles
    // for the pipeline to empty before signalling completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (sweep_start) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                end
            end
            S_SWEEP: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Hit counter: cleared on sweep start, counts only sweep-tagged E=1
    // results, frozen otherwise.
    always_comb begin
        hit_d = hit_q;
        if (sweep_start) begin
            hit_d = '0;
        end else if (busy_q && vld_pipe_q[2] && sw_pipe_q[2] && out_e_q) begin
            hit_d = hit_q + 1'b1;
        end
    end

    // Sweep state registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            hit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            hit_q   <= hit_d;
            busy_q  <= (state_d == S_SWEEP) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign out_bits  = out_bits_q;
    assign out_e     = out_e_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hit_count = hit_q;

endmodule

// File: tb/tb_or_and_sweep.sv
// Bench for or_and_sweep: randomized and directed stimulus, expected results
// queued by the driver and checked by independent output monitors.
module tb_or_and_sweep;

    typedef struct {
        logic [15:0] bits;
        logic        e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode, start, in_valid;
    logic [3:0] in_bits;
    logic       out_valid, out_e, busy, done;
    logic [3:0] out_bits;
    logic [4:0] hit_count;

    logic       v_mode, v_start, v_in_valid;
    logic [2:0] v_in_bits;
    logic       v_out_valid, v_out_e, v_busy, v_done;
    logic [2:0] v_out_bits;
    logic [3:0] v_hit_count;

    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   v_done_cnt = 0;
    exp_t q[$];
    exp_t vq[$];

    always #5 clk = ~clk;

    or_and_sweep #(.N_GROUPS(2), .GROUP_W(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start),
        .in_valid(in_valid), .in_bits(in_bits),
        .out_valid(out_valid), .out_bits(out_bits), .out_e(out_e),
        .busy(busy), .done(done), .hit_count(hit_count)
    );

    or_and_sweep #(.N_GROUPS(3), .GROUP_W(1)) dut_v (
        .clk(clk), .rst(rst), .mode(v_mode), .start(v_start),
        .in_valid(v_in_valid), .in_bits(v_in_bits),
        .out_valid(v_out_valid), .out_bits(v_out_bits), .out_e(v_out_e),
        .busy(v_busy), .done(v_done), .hit_count(v_hit_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // E = every group has at least one bit set.
    function automatic logic model_e(input logic [15:0] v, input int ng, input int gw);
        logic all_ok;
        logic any;
        all_ok = 1'b1;
        for (int gi = 0; gi < ng; gi++) begin
            any = 1'b0;
            for (int b = 0; b < gw; b++)
                if (v[gi*gw + b]) any = 1'b1;
            if (!any) all_ok = 1'b0;
        end
        return all_ok;
    endfunction

    function automatic void push_m(input logic [15:0] v);
        exp_t x;
        x.bits = v;
        x.e    = model_e(v, 2, 2);
        q.push_back(x);
    endfunction

    function automatic int sweep_hits(input int ng, input int gw);
        int n = 0;
        for (int i = 0; i < (1 << (ng*gw)); i++)
            if (model_e(16'(i), ng, gw)) n++;
        return n;
    endfunction

    // Main-DUT monitor
    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(out_bits), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("sb_bits", 32'(out_bits), 32'(e.bits[3:0]));
                chk("sb_e", 32'(out_e), 32'(e.e));
            end
        end
    end

    // Variant-DUT monitor
    always @(negedge clk) begin
        exp_t e;
        if (v_done) v_done_cnt++;
        if (v_out_valid) begin
            if (vq.size() == 0) begin
                chk("v_sb_underflow", 32'(v_out_bits), 32'hFFFF_FFFF);
            end else begin
                e = vq.pop_front();
                chk("v_sb_bits", 32'(v_out_bits), 32'(e.bits[2:0]));
                chk("v_sb_e", 32'(v_out_e), 32'(e.e));
            end
        end
    end

    task automatic do_sweep(input bit noise, input int exp_hits);
        int d0;
        int k;
        @(negedge clk);
        d0 = done_cnt;
        // External operand on the start cycle is still accepted but not counted.
        mode = 1'b1; start = 1'b1; in_valid = 1'b1; in_bits = 4'hF;
        push_m(16'hF);
        for (int i = 0; i < 16; i++) push_m(16'(i));
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; mode = 1'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 60) begin
            if (noise && k < 10) begin
                in_valid = 1'b1; in_bits = 4'hF; start = 1'b1; mode = 1'b1;
            end else begin
                in_valid = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0; start = 1'b0; mode = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("hit_at_done", 32'(hit_count), 32'(exp_hits));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("sb_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int hits4;
        int hits3;
        int d0;
        int k;
        logic [3:0] b2b [4];
        b2b[0] = 4'b0011; b2b[1] = 4'b1100; b2b[2] = 4'b1010; b2b[3] = 4'b0000;
        hits4 = sweep_hits(2, 2);
        hits3 = sweep_hits(3, 1);

        rst = 1'b1; mode = 1'b0; start = 1'b0; in_valid = 1'b0; in_bits = '0;
        v_mode = 1'b0; v_start = 1'b0; v_in_valid = 1'b0; v_in_bits = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bits", 32'(out_bits), 32'd0);
        chk("rst_out_e", 32'(out_e), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit", 32'(hit_count), 32'd0);
        rst = 1'b0;

        // Single operand: exact two-edge latency, one-cycle valid.
        @(negedge clk);
        in_valid = 1'b1; in_bits = 4'b0101; push_m(16'b0101);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_edge1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge2", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("lat_after", 32'(out_valid), 32'd0);
        chk("hold_bits", 32'(out_bits), 32'b0101);

        // Back-to-back operands.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_bits = b2b[i]; push_m(16'(b2b[i]));
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Random external traffic.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_bits  = 4'($urandom);
            if (in_valid) push_m(16'(in_bits));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Clean sweep.
        do_sweep(1'b0, hits4);

        // External traffic afterwards must leave hit_count untouched.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_bits = 4'($urandom); push_m(16'(in_bits));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("hit_held", 32'(hit_count), 32'(hits4));

        // Sweep with dropped operands and ignored start pulses.
        do_sweep(1'b1, hits4);

        // Reset at sweep step 7.
        @(negedge clk);
        mode = 1'b1; start = 1'b1;
        for (int i = 0; i < 16; i++) push_m(16'(i));
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_bits", 32'(out_bits), 32'd0);
        chk("mid_rst_out_e", 32'(out_e), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hit", 32'(hit_count), 32'd0);
        q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_idle_busy", 32'(busy), 32'd0);

        do_sweep(1'b0, hits4);

        // Variant N_GROUPS=3, GROUP_W=1.
        @(negedge clk);
        v_mode = 1'b1; v_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_t x;
            x.bits = 16'(i);
            x.e    = model_e(16'(i), 3, 1);
            vq.push_back(x);
        end
        @(negedge clk);
        v_start = 1'b0; v_mode = 1'b0;
        k = 0;
        while (!v_done && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("v_done_seen", 32'(v_done), 32'd1);
        chk("v_hit", 32'(v_hit_count), 32'(hits3));
        @(negedge clk);
        chk("v_sb_drained", 32'(vq.size()), 32'd0);
        chk("v_done_pulses", 32'(v_done_cnt), 32'd1);

        repeat (4) @(negedge clk);
        chk("final_sb_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
